vga_timing_gen: RTL and testbench

- VGA timing generator for the Pong video path at 640x480@60 (25 MHz pixel rate).
- Produces the active-high hs/vs that the scan doubler's read side uses to restart lines and frames and to blank its output.
- Also drives the monitor sync pins (polarity selectable), blank, and the pixel/line counters.
- Optional genlock: re-phases the VGA frame to the source game's vsync, so the doubled picture does not roll vertically.

---
 rtl/pong_video_pkg.sv | 32 +++
 rtl/sync_edge_det.sv | 35 +++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_video_pkg.sv
// pong_video_pkg
//   Shared constants for the Pong video path: 640x480@60 timing at a 25 MHz
//   pixel rate, the beam counter width, and the sync pin polarity values.
//   pin_level() maps an active-high sync onto a connector pin of either
//   polarity.
package pong_video_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // Pin level for an active-high sync: high when active == pol.
  function automatic logic pin_level(input logic active, input bit pol);
    return ~(active ^ pol);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Two-flop synchroniser for an asynchronous level, followed by a
//   rising-edge detector in the destination clock domain.
// Ports:
//   clk   in   destination clock
//   rst_n in   asynchronous active-low reset
//   d     in   asynchronous level
//   rise  out  one-cycle pulse after a synchronised 0->1 transition
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // sync_p0 -> sync_p1 is the metastability stage; edge is taken on sync_p1
  assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA beam timing for the Pong video path. Generates the pixel/line
//   counters, active-high hs/vs for the scan doubler, polarity-adjusted
//   connector syncs, blank and a frame_start pulse. Optional genlock
//   re-phases the frame to the source game's vsync by loading LOCK_LINE
//   into vcount at a line end.
// Ports:
//   clkvga      in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   ce          in   pixel enable, counters advance only when high
//   lock_en     in   genlock enable
//   vs_src      in   source vsync, asynchronous, active-high
//   hcount      out  pixel column 0..H_TOTAL-1
//   vcount      out  line 0..V_TOTAL-1
//   hs, vs      out  active-high syncs aligned with the counters
//   hs_pin      out  hs at connector polarity HS_POL
//   vs_pin      out  vs at connector polarity VS_POL
//   blank       out  high outside the active picture
//   frame_start out  one-cycle pulse when the counters reach 0/0
//   locked      out  last genlock load matched the free-running phase
module vga_timing_gen
  import pong_video_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int LOCK_LINE = 0,
  parameter bit HS_POL    = POL_ACTIVE_LOW,
  parameter bit VS_POL    = POL_ACTIVE_LOW
) (
  input  logic             clkvga,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             lock_en,
  input  logic             vs_src,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hs,
  output logic             vs,
  output logic             hs_pin,
  output logic             vs_pin,
  output logic             blank,
  output logic             frame_start,
  output logic             locked
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HS_START = H_ACTIVE + H_FP;
  localparam int   HS_STOP  = HS_START + H_SYNC;
  localparam int   VS_START = V_ACTIVE + V_FP;
  localparam int   VS_STOP  = VS_START + V_SYNC;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t LOCK_V   = cnt_t'(LOCK_LINE);

  function automatic logic in_span(input cnt_t val, input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) < hi);
  endfunction

  function automatic logic outside(input cnt_t val, input int limit);
    return int'(val) >= limit;
  endfunction

  logic src_rise;
  logic req_pending;
  logic line_end;
  logic apply_lock;
  cnt_t h_nxt;
  cnt_t v_nat;
  cnt_t v_nxt;
  logic hs_nxt;
  logic vs_nxt;
  logic blank_nxt;
  logic fs_nxt;

  sync_edge_det u_vs_sync (
    .clk   (clkvga),
    .rst_n (rst_n),
    .d     (vs_src),
    .rise  (src_rise)
  );

  // Next counter values; all decode is taken from these so the registered
  // syncs and blank line up with the registered counters.
  always_comb begin
    line_end   = ce && (hcount == H_LAST);
    apply_lock = line_end && req_pending && lock_en;
    h_nxt      = line_end ? '0 : hcount + cnt_t'(1);
    v_nat      = vcount;
    if (line_end) begin
      v_nat = (vcount == V_LAST) ? '0 : vcount + cnt_t'(1);
    end
    v_nxt     = apply_lock ? LOCK_V : v_nat;
    hs_nxt    = in_span(h_nxt, HS_START, HS_STOP);
    vs_nxt    = in_span(v_nxt, VS_START, VS_STOP);
    blank_nxt = outside(h_nxt, H_ACTIVE) || outside(v_nxt, V_ACTIVE);
    fs_nxt    = (h_nxt == '0) && (v_nxt == '0);
  end

  // Beam counters and decoded outputs
  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      hs_pin      <= pin_level(1'b0, HS_POL);
      vs_pin      <= pin_level(1'b0, VS_POL);
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hs          <= hs_nxt;
      vs          <= vs_nxt;
      hs_pin      <= pin_level(hs_nxt, HS_POL);
      vs_pin      <= pin_level(vs_nxt, VS_POL);
      blank       <= blank_nxt;
      frame_start <= fs_nxt;
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Genlock request and status. The request is sampled at a line end before
  // any edge of the same cycle is latched, so a coincident edge waits for the
  // following line end; an edge while a request is pending is absorbed.
  always_ff @(posedge clkvga or negedge rst_n) begin
    if (!rst_n) begin
      req_pending <= 1'b0;
      locked      <= 1'b0;
    end else if (!lock_en) begin
      req_pending <= 1'b0;
      locked      <= 1'b0;
    end else begin
      if (apply_lock) begin
        req_pending <= 1'b0;
        locked      <= (v_nat == LOCK_V);
      end else if (src_rise) begin
        req_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Reduced timing for the instance that runs whole frames
  localparam int SHA = 40, SHF = 4, SHS = 8, SHB = 8;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVA = 30, SVF = 3, SVS = 2, SVB = 5;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int S_LOCK = 0;
  localparam bit S_HS_POL = 1'b1;
  localparam bit S_VS_POL = 1'b0;

  logic clk = 1'b0;
  logic rst_n, ce, lock_en, vs_src;

  logic [9:0] d_hcount, d_vcount, s_hcount, s_vcount;
  logic d_hs, d_vs, d_hs_pin, d_vs_pin, d_blank, d_frame_start, d_locked;
  logic s_hs, s_vs, s_hs_pin, s_vs_pin, s_blank, s_frame_start, s_locked;
  logic [26:0] d_obs, s_obs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_full (
    .clkvga(clk), .rst_n(rst_n), .ce(ce), .lock_en(lock_en), .vs_src(vs_src),
    .hcount(d_hcount), .vcount(d_vcount), .hs(d_hs), .vs(d_vs),
    .hs_pin(d_hs_pin), .vs_pin(d_vs_pin), .blank(d_blank),
    .frame_start(d_frame_start), .locked(d_locked)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .LOCK_LINE(S_LOCK), .HS_POL(S_HS_POL), .VS_POL(S_VS_POL)
  ) u_dut_small (
    .clkvga(clk), .rst_n(rst_n), .ce(ce), .lock_en(lock_en), .vs_src(vs_src),
    .hcount(s_hcount), .vcount(s_vcount), .hs(s_hs), .vs(s_vs),
    .hs_pin(s_hs_pin), .vs_pin(s_vs_pin), .blank(s_blank),
    .frame_start(s_frame_start), .locked(s_locked)
  );

  assign d_obs = {d_hcount, d_vcount, d_hs, d_vs, d_hs_pin, d_vs_pin, d_blank, d_frame_start, d_locked};
  assign s_obs = {s_hcount, s_vcount, s_hs, s_vs, s_hs_pin, s_vs_pin, s_blank, s_frame_start, s_locked};

  // Reference model of the small instance: beam position as plain integers,
  // vs_src history as seen through two sync stages plus the edge stage.
  int m_h, m_v, m_nat;
  bit m_fs, m_lock, m_pend, x1, x2, x3, m_edge, m_le, m_apply;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_fs = 0; m_lock = 0; m_pend = 0;
      x1 = 0; x2 = 0; x3 = 0;
    end else begin
      m_edge  = x2 && !x3;
      m_le    = ce && (m_h == SHT - 1);
      m_apply = m_le && m_pend && lock_en;
      m_nat   = (m_v + 1) % SVT;
      if (!lock_en) m_lock = 0;
      else if (m_apply) m_lock = (m_nat == S_LOCK);
      if (!lock_en) m_pend = 0;
      else if (m_apply) m_pend = 0;
      else if (m_edge) m_pend = 1;
      if (ce) begin
        m_h = (m_h + 1) % SHT;
        if (m_le) m_v = m_apply ? S_LOCK : m_nat;
      end
      m_fs = ce && (m_h == 0) && (m_v == 0);
      x3 = x2; x2 = x1; x1 = vs_src;
    end
  end

  function automatic logic [26:0] exp_vec();
    logic hs_e, vs_e, bl_e;
    hs_e = (m_h >= SHA + SHF) && (m_h < SHA + SHF + SHS);
    vs_e = (m_v >= SVA + SVF) && (m_v < SVA + SVF + SVS);
    bl_e = (m_h >= SHA) || (m_v >= SVA);
    return {10'(m_h), 10'(m_v), hs_e, vs_e, ~(hs_e ^ S_HS_POL), ~(vs_e ^ S_VS_POL), bl_e, m_fs, m_lock};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int found;
    ce = 1'b1; lock_en = 1'b0; vs_src = 1'b0;
    do_reset();
    repeat (700) @(posedge clk);
    #1;
    total++;
    if (d_hcount !== 10'd700 || d_hs !== 1'b1 || d_blank !== 1'b1) begin
      bad++; $display("FAIL pre_reset got h=%0d hs=%b blank=%b want h=700 hs=1 blank=1", d_hcount, d_hs, d_blank);
    end
    #2; rst_n = 1'b0; #1;
    total++;
    if (d_obs !== {20'd0, 7'b0011000}) begin
      bad++; $display("FAIL reset_full got=%h want=%h", d_obs, {20'd0, 7'b0011000});
    end
    total++;
    if (s_obs !== {20'd0, 7'b0001000}) begin
      bad++; $display("FAIL reset_small got=%h want=%h", s_obs, {20'd0, 7'b0001000});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    found = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      if (s_frame_start === 1'b1) begin found = n; break; end
    end
    total++;
    if (found != SHT * SVT || s_hcount !== 10'd0 || s_vcount !== 10'd0) begin
      bad++; $display("FAIL fs_after_reset got cycle=%0d h=%0d v=%0d want cycle=%0d h=0 v=0", found, s_hcount, s_vcount, SHT * SVT);
    end
    @(posedge clk); #1;
    total++;
    if (s_frame_start !== 1'b0) begin
      bad++; $display("FAIL fs_width got=%b want=0", s_frame_start);
    end
  endtask

  task automatic test_line_timing();
    int hs_first, hs_len, bl_first, bl_len;
    hs_first = -1; hs_len = 0; bl_first = -1; bl_len = 0;
    ce = 1'b1;
    do_reset();
    for (int n = 1; n <= 800; n++) begin
      @(posedge clk); #1;
      if (n < 800) begin
        total++;
        if (d_hcount !== 10'(n) || d_vcount !== 10'd0) begin
          bad++; $display("FAIL line_count got h=%0d v=%0d want h=%0d v=0", d_hcount, d_vcount, n);
        end
      end
      if (d_hs === 1'b1) begin
        if (hs_first < 0) hs_first = int'(d_hcount);
        hs_len++;
      end
      if (d_blank === 1'b1) begin
        if (bl_first < 0) bl_first = int'(d_hcount);
        bl_len++;
      end
    end
    total++;
    if (d_hcount !== 10'd0 || d_vcount !== 10'd1) begin
      bad++; $display("FAIL line_wrap got h=%0d v=%0d want h=0 v=1", d_hcount, d_vcount);
    end
    total++;
    if (hs_first != 656 || hs_len != 96) begin
      bad++; $display("FAIL hs_window got start=%0d len=%0d want start=656 len=96", hs_first, hs_len);
    end
    total++;
    if (bl_first != 640 || bl_len != 160) begin
      bad++; $display("FAIL blank_window got start=%0d len=%0d want start=640 len=160", bl_first, bl_len);
    end
  endtask

  task automatic test_frame();
    int vs_cnt, fs_cnt;
    vs_cnt = 0; fs_cnt = 0;
    ce = 1'b1; lock_en = 1'b0;
    for (int n = 0; n < 2 * SHT * SVT; n++) begin
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL frame_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
      if (s_vs === 1'b1) vs_cnt++;
      if (s_frame_start === 1'b1) fs_cnt++;
    end
    total++;
    if (vs_cnt != 2 * SVS * SHT || fs_cnt != 2) begin
      bad++; $display("FAIL frame_counts got vs=%0d fs=%0d want vs=%0d fs=2", vs_cnt, fs_cnt, 2 * SVS * SHT);
    end
  endtask

  task automatic test_ce_gating();
    int last, fs_cnt;
    logic prev_fs;
    last = -1; fs_cnt = 0; prev_fs = 1'b0;
    ce = 1'b0;
    for (int n = 0; n < 4 * SHT * SVT; n++) begin
      @(negedge clk); ce = ~ce;
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL ce_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
      if (s_frame_start === 1'b1) begin
        total++;
        if (prev_fs !== 1'b0) begin bad++; $display("FAIL ce_fs_width got two-cycle pulse want one"); end
        if (last >= 0) begin
          total++;
          if (n - last != 2 * SHT * SVT) begin
            bad++; $display("FAIL ce_frame_len got=%0d want=%0d", n - last, 2 * SHT * SVT);
          end
        end
        last = n; fs_cnt++;
      end
      prev_fs = s_frame_start;
    end
    total++;
    if (fs_cnt != 2) begin bad++; $display("FAIL ce_fs_count got=%0d want=2", fs_cnt); end
    @(negedge clk); ce = 1'b1;
  endtask

  task automatic test_genlock_jump();
    bit ok;
    logic [7:0] pat;
    pat = 8'b0110_0011;
    ce = 1'b1; lock_en = 1'b1; vs_src = 1'b0;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL jump_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
      if (s_vcount === 10'd10 && s_hcount === 10'd2) begin ok = 1; break; end
    end
    ok = ok && 1'b1;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk); vs_src = (i < 8) ? pat[i] : 1'b0;
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL jump_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
      if (s_hcount === 10'd0) break;
    end
    total++;
    if (!ok || s_hcount !== 10'd0 || s_vcount !== 10'(S_LOCK) || s_locked !== 1'b0) begin
      bad++; $display("FAIL jump_load got ok=%0d h=%0d v=%0d locked=%b want h=0 v=%0d locked=0", ok, s_hcount, s_vcount, s_locked, S_LOCK);
    end
    repeat (SHT) begin
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL jump_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
    end
    total++;
    if (s_vcount !== 10'(S_LOCK + 1)) begin
      bad++; $display("FAIL jump_no_extra got v=%0d want v=%0d", s_vcount, S_LOCK + 1);
    end
  endtask

  task automatic test_edge_at_line_end();
    bit ok;
    ce = 1'b1; vs_src = 1'b0;
    @(negedge clk); lock_en = 1'b0;
    @(negedge clk); lock_en = 1'b1;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL coinc_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
      if (s_vcount === 10'd5 && s_hcount === 10'(SHT - 3)) begin ok = 1; break; end
    end
    // Rise becomes visible two clocks later, in the line-end cycle itself
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); vs_src = 1'b1;
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL coinc_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
    end
    @(negedge clk); vs_src = 1'b0;
    total++;
    if (!ok || s_hcount !== 10'd0 || s_vcount !== 10'd6) begin
      bad++; $display("FAIL coinc_deferred got ok=%0d h=%0d v=%0d want h=0 v=6", ok, s_hcount, s_vcount);
    end
    repeat (SHT) begin
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL coinc_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
    end
    total++;
    if (s_vcount !== 10'(S_LOCK)) begin
      bad++; $display("FAIL coinc_applied got v=%0d want v=%0d", s_vcount, S_LOCK);
    end
  endtask

  task automatic test_genlock_hold();
    bit ok;
    ce = 1'b1; lock_en = 1'b1; vs_src = 1'b0;
    for (int f = 0; f < 3; f++) begin
      ok = 0;
      for (int n = 0; n < 3000; n++) begin
        @(posedge clk); #1;
        total++;
        if (s_obs !== exp_vec()) begin bad++; $display("FAIL hold_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
        if (s_vcount === 10'(SVT - 1) && s_hcount === 10'd5) begin ok = 1; break; end
      end
      for (int i = 0; i < SHT && ok; i++) begin
        @(negedge clk); vs_src = (i < 3);
        @(posedge clk); #1;
        total++;
        if (s_obs !== exp_vec()) begin bad++; $display("FAIL hold_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
        if (s_hcount === 10'd0) break;
      end
      vs_src = 1'b0;
      total++;
      if (!ok || s_hcount !== 10'd0 || s_vcount !== 10'd0 || s_locked !== 1'b1) begin
        bad++; $display("FAIL hold_lock frame=%0d got ok=%0d h=%0d v=%0d locked=%b want h=0 v=0 locked=1", f, ok, s_hcount, s_vcount, s_locked);
      end
    end
    @(negedge clk); lock_en = 1'b0;
    @(posedge clk); #1;
    total++;
    if (s_locked !== 1'b0) begin bad++; $display("FAIL unlock got locked=%b want 0", s_locked); end
  endtask

  task automatic test_random();
    ce = 1'b1; lock_en = 1'b1; vs_src = 1'b0;
    for (int n = 0; n < 12000; n++) begin
      @(negedge clk);
      ce = ($urandom_range(3) != 0);
      if ($urandom_range(499) == 0) lock_en = ~lock_en;
      if ($urandom_range(99) == 0) vs_src = ~vs_src;
      @(posedge clk); #1;
      total++;
      if (s_obs !== exp_vec()) begin bad++; $display("FAIL random_model t=%0t got=%h want=%h", $time, s_obs, exp_vec()); end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; lock_en = 1'b0; vs_src = 1'b0;
    test_reset();
    test_line_timing();
    test_frame();
    test_ce_gating();
    test_genlock_jump();
    test_edge_at_line_end();
    test_genlock_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
